// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: register-file addressing, writeback bypass,
// immediate generation, and a single ID/EX output register with handshake.
module decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_wen,
  input  logic [4:0]      wb_a3,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam int unsigned RegAw = 5;
  localparam int unsigned OpW   = 7;

  localparam logic [OpW-1:0] OpLoad   = 7'b0000011;
  localparam logic [OpW-1:0] OpImm    = 7'b0010011;
  localparam logic [OpW-1:0] OpJalr   = 7'b1100111;
  localparam logic [OpW-1:0] OpStore  = 7'b0100011;
  localparam logic [OpW-1:0] OpBranch = 7'b1100011;
  localparam logic [OpW-1:0] OpLui    = 7'b0110111;
  localparam logic [OpW-1:0] OpAuipc  = 7'b0010111;
  localparam logic [OpW-1:0] OpJal    = 7'b1101111;
  localparam logic [OpW-1:0] OpReg    = 7'b0110011;

  logic [RegAw-1:0] rs1_c, rs2_c;
  logic [XLEN-1:0]  imm_c, rs1_val_c, rs2_val_c;
  logic             illegal_c;
  logic             capture_c, hold_c;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [OpW-1:0]   opcode_q, opcode_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             funct7b5_q, funct7b5_d;
  logic [RegAw-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0]  rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic             illegal_q, illegal_d;

  assign rs1_c     = in_instr[19:15];
  assign rs2_c     = in_instr[24:20];
  assign rf_a1     = rs1_c;
  assign rf_a2     = rs2_c;
  assign in_ready  = ~out_valid_q | out_ready;
  assign capture_c = in_valid & in_ready & ~flush;
  assign hold_c    = out_valid_q & ~out_ready;

  // Immediate selection and legality check from the opcode
  always_comb begin
    imm_c     = '0;
    illegal_c = 1'b0;
    case (in_instr[6:0])
      OpLoad, OpImm, OpJalr: imm_c = {{20{in_instr[31]}}, in_instr[31:20]};
      OpStore:  imm_c = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      OpBranch: imm_c = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
      OpLui, OpAuipc: imm_c = {in_instr[31:12], 12'b0};
      OpJal:    imm_c = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
      OpReg:    imm_c = '0;
      default:  illegal_c = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) illegal_c = 1'b1;
  end

  // Operand select: x0 reads zero, same-cycle writeback wins over the register file
  always_comb begin
    rs1_val_c = rf_rd1;
    rs2_val_c = rf_rd2;
    if (rs1_c == '0)                       rs1_val_c = '0;
    else if (wb_wen && (wb_a3 == rs1_c))   rs1_val_c = wb_wd;
    if (rs2_c == '0)                       rs2_val_c = '0;
    else if (wb_wen && (wb_a3 == rs2_c))   rs2_val_c = wb_wd;
  end

  // ID/EX register next state: flush > capture > consume, plus stale-operand refresh while held
  always_comb begin
    out_valid_d = out_valid_q;
    pc_d        = pc_q;
    opcode_d    = opcode_q;
    funct3_d    = funct3_q;
    funct7b5_d  = funct7b5_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    imm_d       = imm_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture_c) begin
      out_valid_d = 1'b1;
      pc_d        = in_pc;
      opcode_d    = in_instr[6:0];
      funct3_d    = in_instr[14:12];
      funct7b5_d  = in_instr[30];
      rd_d        = in_instr[11:7];
      rs1_d       = rs1_c;
      rs2_d       = rs2_c;
      rs1_val_d   = rs1_val_c;
      rs2_val_d   = rs2_val_c;
      imm_d       = imm_c;
      illegal_d   = illegal_c;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (hold_c && wb_wen && (wb_a3 != '0)) begin
      if (wb_a3 == rs1_q) rs1_val_d = wb_wd;
      if (wb_a3 == rs2_q) rs2_val_d = wb_wd;
    end
  end

  // ID/EX state register, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7b5_q  <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      imm_q       <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      opcode_q    <= opcode_d;
      funct3_q    <= funct3_d;
      funct7b5_q  <= funct7b5_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      imm_q       <= imm_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = pc_q;
  assign out_opcode   = opcode_q;
  assign out_funct3   = funct3_q;
  assign out_funct7b5 = funct7b5_q;
  assign out_rd       = rd_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_rs1_val  = rs1_val_q;
  assign out_rs2_val  = rs2_val_q;
  assign out_imm      = imm_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push expected bundles,
// a monitor pops and compares on every accepted output.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic        illegal;
  } bundle_t;

  logic        clk, reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_wen;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_rs1_val, out_rs2_val, out_imm;
  logic        out_illegal;

  bundle_t act_b;
  bundle_t exp_q[$];
  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_wen(wb_wen), .wb_a3(wb_a3), .wb_wd(wb_wd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  assign act_b = {out_pc, out_opcode, out_funct3, out_funct7b5, out_rd, out_rs1,
                  out_rs2, out_rs1_val, out_rs2_val, out_imm, out_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bundle_t eb(input logic [31:0] pc, input logic [6:0] op,
                                 input logic [2:0] f3, input logic f7b5,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] v1,
                                 input logic [31:0] v2, input logic [31:0] imm,
                                 input logic ill);
    bundle_t b;
    b = {pc, op, f3, f7b5, rd, rs1, rs2, v1, v2, imm, ill};
    return b;
  endfunction

  // Drive one bundle for a single cycle; optionally record its expected decode
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic wen, input logic [4:0] a3, input logic [31:0] wd,
                       input logic fl, input logic push, input bundle_t e);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    rf_rd1 = rd1; rf_rd2 = rd2;
    wb_wen = wen; wb_a3 = a3; wb_wd = wd; flush = fl;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; wb_wen = 1'b0; flush = 1'b0;
  endtask

  // Monitor: every accepted output bundle must match the oldest expectation
  initial begin
    bundle_t e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bundle", 192'(act_b), 192'(0));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("bundle_pc_%0h", e.pc), 192'(act_b), 192'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bundle_t z;
    z = '0;
    reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rf_rd1 = '0; rf_rd2 = '0; wb_wen = 1'b0; wb_a3 = '0; wb_wd = '0;
    flush = 1'b0; out_ready = 1'b1;

    #12;
    check("reset_valid", 192'(out_valid), 192'(0));
    check("reset_in_ready", 192'(in_ready), 192'(1));
    check("reset_fields", 192'(act_b), 192'(0));
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    in_instr = 32'h002081B3; #1;
    check("rf_addr", 192'({rf_a1, rf_a2}), 192'({5'd1, 5'd2}));

    // addi x1,x0,5: x0 source ignores rf data
    issue(32'h00500093, 32'h100, 32'hDEAD, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
          eb(32'h100, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd5, 32'h0, 32'h55, 32'h5, 1'b0));
    // add x3,x1,x2 with same-cycle writeback to x1
    issue(32'h002081B3, 32'h104, 32'h0, 32'h7, 1'b1, 5'd1, 32'h1234, 1'b0, 1'b1,
          eb(32'h104, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h1234, 32'h7, 32'h0, 1'b0));
    // same, but writeback to x0 must not bypass
    issue(32'h002081B3, 32'h108, 32'h0, 32'h7, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1,
          eb(32'h108, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h7, 32'h0, 1'b0));

    // held bundle gets its rs2 refreshed; a new bundle is refused
    issue(32'h002081B3, 32'h10C, 32'h0, 32'h7, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
          eb(32'h10C, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 32'hABCD, 32'h0, 1'b0));
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h200;
    wb_wen = 1'b1; wb_a3 = 5'd2; wb_wd = 32'hABCD;
    @(negedge clk);
    check("hold_in_ready", 192'(in_ready), 192'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; wb_wen = 1'b0;
    @(negedge clk);
    check("hold_valid", 192'(out_valid), 192'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;

    // immediate forms and illegal encoding
    issue(32'hFE000EE3, 32'h110, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
          eb(32'h110, 7'h63, 3'd0, 1'b1, 5'd29, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFC, 1'b0));
    issue(32'h123450B7, 32'h114, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
          eb(32'h114, 7'h37, 3'd5, 1'b0, 5'd1, 5'd8, 5'd3, 32'h11, 32'h22, 32'h12345000, 1'b0));
    issue(32'h008000EF, 32'h118, 32'h33, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
          eb(32'h118, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd8, 32'h0, 32'h99, 32'h8, 1'b0));
    issue(32'hFFFFFFFF, 32'h11C, 32'hA, 32'hB, 1'b1, 5'd31, 32'h77, 1'b0, 1'b1,
          eb(32'h11C, 7'h7F, 3'd7, 1'b1, 5'd31, 5'd31, 5'd31, 32'h77, 32'h77, 32'h0, 1'b1));

    // flush blocks a capture at the same edge
    issue(32'h00500093, 32'h300, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, z);
    @(negedge clk);
    check("flush_capture_valid", 192'(out_valid), 192'(0));

    // flush while stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(32'h123450B7, 32'h400, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, z);
    @(negedge clk);
    check("stall_valid", 192'(out_valid), 192'(1));
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_stall_valid", 192'(out_valid), 192'(0));
    check("flush_stall_in_ready", 192'(in_ready), 192'(1));

    // asynchronous reset mid-stall
    issue(32'h008000EF, 32'h500, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, z);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 192'(out_valid), 192'(0));
    check("async_rst_fields", 192'(act_b), 192'(0));
    check("async_rst_in_ready", 192'(in_ready), 192'(1));
    #1 reset_n = 1'b1;
    out_ready = 1'b1;

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_empty", 192'(exp_q.size()), 192'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
